// File: rtl/ee354_2048_pkg.sv
// ee354_2048_pkg: direction indices, one-hot move codes and conditioner FSM states
// shared by the move button conditioner and the 2048 game FSM.
package ee354_2048_pkg;
    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;
    localparam logic [3:0] MOVE_NONE  = 4'b0000;
    localparam logic [3:0] MOVE_UP    = 4'b0001;
    localparam logic [3:0] MOVE_DOWN  = 4'b0010;
    localparam logic [3:0] MOVE_LEFT  = 4'b0100;
    localparam logic [3:0] MOVE_RIGHT = 4'b1000;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    function automatic logic [3:0] pick_move(input logic [3:0] p);
        return p[DIR_UP]    ? MOVE_UP    :
               p[DIR_DOWN]  ? MOVE_DOWN  :
               p[DIR_LEFT]  ? MOVE_LEFT  :
               p[DIR_RIGHT] ? MOVE_RIGHT : MOVE_NONE;
    endfunction
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchroniser, consecutive-cycle debounce counter,
// stable level and one-cycle rising-edge press of the debounced level.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic Clk,
    input  logic Reset,
    input  logic i_btn,
    output logic o_stable,
    output logic o_press
);
    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic             r_stable_d;
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_meta     <= 1'b0;
            r_sync     <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_meta     <= i_btn;
            r_sync     <= r_meta;
            r_stable_d <= r_stable;
            if (r_sync == r_stable)
                r_cnt <= '0;
            else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= r_sync;
                r_cnt    <= '0;
            end else
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end
    assign o_stable = r_stable;
    assign o_press  = r_stable & ~r_stable_d;
endmodule

// File: rtl/move_button_conditioner.sv
// move_button_conditioner: debounces four move buttons and issues one prioritised,
// one-cycle move pulse per press, then holds off until every button is released.
module move_button_conditioner
    import ee354_2048_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic Clk,
    input  logic Reset,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_left,
    input  logic btn_right,
    input  logic enable,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic busy
);
    logic [3:0] w_btn;
    logic [3:0] w_stable;
    logic [3:0] w_press;
    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [3:0] r_move;
    logic [3:0] w_next_move;
    assign w_btn = {btn_right, btn_left, btn_down, btn_up};
    for (genvar i = 0; i < 4; i++) begin : g_db
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W(CNT_W)
        ) u_db (
            .Clk(Clk),
            .Reset(Reset),
            .i_btn(w_btn[i]),
            .o_stable(w_stable[i]),
            .o_press(w_press[i])
        );
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_move  <= MOVE_NONE;
        end else begin
            r_state <= w_next_state;
            r_move  <= w_next_move;
        end
    end
    always_comb begin
        w_next_state = (r_state == ST_IDLE)  ? ((enable && |w_press) ? ST_PULSE : ST_IDLE) :
                       (r_state == ST_PULSE) ? ST_HOLD :
                       (|w_stable)           ? ST_HOLD : ST_IDLE;
    end
    // Presses outside IDLE or with enable low are dropped, not queued.
    always_comb begin
        w_next_move = (r_state == ST_IDLE && enable) ? pick_move(w_press) : MOVE_NONE;
    end
    assign up    = r_move[DIR_UP];
    assign down  = r_move[DIR_DOWN];
    assign left  = r_move[DIR_LEFT];
    assign right = r_move[DIR_RIGHT];
    assign busy  = (r_state == ST_PULSE) || (r_state == ST_HOLD);
endmodule

// File: tb/tb_move_button_conditioner.sv
// tb_move_button_conditioner: directed vector table and random bounce run checked
// against a cycle model, plus a DEBOUNCE_CYCLES=1 instance.
module tb_move_button_conditioner;
    localparam int DC = 4;
    typedef struct {
        string      nm;
        logic       rst;
        logic [3:0] btn;
        logic       en;
        logic [3:0] mv;
        logic       bz;
    } vec_t;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic       en;
    logic       up, down, left, right, busy;
    logic       u1_btn;
    logic       up1, down1, left1, right1, busy1;
    int         checks = 0;
    int         errors = 0;
    vec_t       tbl[$];
    logic [3:0] m_meta, m_sync, m_stab, m_stabd, m_move;
    logic [1:0] m_st;
    int         m_run[4];
    always #5 clk = ~clk;
    move_button_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) u_dut (
        .Clk(clk), .Reset(rst),
        .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]),
        .enable(en),
        .up(up), .down(down), .left(left), .right(right), .busy(busy)
    );
    move_button_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(1)) u_dut1 (
        .Clk(clk), .Reset(rst),
        .btn_up(u1_btn), .btn_down(1'b0), .btn_left(1'b0), .btn_right(1'b0),
        .enable(1'b1),
        .up(up1), .down(down1), .left(left1), .right(right1), .busy(busy1)
    );
    task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp || !$onehot0(act[4:1])) begin
            errors++;
            $display("FAIL %s @%0t: {move,busy} got %b want %b", nm, $time, act, exp);
        end
    endtask
    task automatic add(input int n, input string nm, input logic r, input logic [3:0] b,
                       input logic e, input logic [3:0] mv, input logic bz);
        for (int k = 0; k < n; k++) tbl.push_back('{nm, r, b, e, mv, bz});
    endtask
    task automatic model_reset();
        m_meta = '0; m_sync = '0; m_stab = '0; m_stabd = '0; m_move = '0; m_st = 2'd0;
        for (int b = 0; b < 4; b++) m_run[b] = 0;
    endtask
    // Advances the reference model across one rising edge.
    task automatic model_step(input logic [3:0] raw, input logic e);
        logic [3:0] p, nm;
        logic [1:0] ns;
        p  = m_stab & ~m_stabd;
        nm = (m_st == 2'd0 && e) ? (p & (~p + 4'd1)) : 4'd0;
        ns = (m_st == 2'd0) ? ((e && p != 0) ? 2'd1 : 2'd0) :
             (m_st == 2'd1) ? 2'd2 : ((m_stab == 0) ? 2'd0 : 2'd2);
        m_stabd = m_stab;
        for (int b = 0; b < 4; b++) begin
            if (m_sync[b] == m_stab[b]) m_run[b] = 0;
            else if (m_run[b] == DC - 1) begin
                m_stab[b] = m_sync[b];
                m_run[b]  = 0;
            end else m_run[b]++;
        end
        m_sync = m_meta;
        m_meta = raw;
        m_move = nm;
        m_st   = ns;
    endtask
    initial begin
        int n_pulse, n_exp;
        logic [3:0] rb;
        logic re;
        rst = 1'b1; btn = '0; en = 1'b1; u1_btn = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("reset", {right, left, down, up, busy}, 5'b0);
        chk("reset_dc1", {right1, left1, down1, up1, busy1}, 5'b0);
        add(6, "clean_up",   0, 4'b0001, 1, 4'b0000, 0);
        add(1, "clean_up",   0, 4'b0001, 1, 4'b0001, 1);
        add(2, "clean_up",   0, 4'b0001, 1, 4'b0000, 1);
        add(6, "up_release", 0, 4'b0000, 1, 4'b0000, 1);
        add(2, "up_release", 0, 4'b0000, 1, 4'b0000, 0);
        add(1, "left_bounce", 0, 4'b0100, 1, 4'b0000, 0);
        add(1, "left_bounce", 0, 4'b0000, 1, 4'b0000, 0);
        add(1, "left_bounce", 0, 4'b0100, 1, 4'b0000, 0);
        add(1, "left_bounce", 0, 4'b0000, 1, 4'b0000, 0);
        add(6, "left_bounce", 0, 4'b0100, 1, 4'b0000, 0);
        add(1, "left_pulse",  0, 4'b0100, 1, 4'b0100, 1);
        add(2, "left_hold",   0, 4'b0100, 1, 4'b0000, 1);
        add(6, "left_rel",    0, 4'b0000, 1, 4'b0000, 1);
        add(2, "left_rel",    0, 4'b0000, 1, 4'b0000, 0);
        add(6, "down_right",  0, 4'b1010, 1, 4'b0000, 0);
        add(1, "down_wins",   0, 4'b1010, 1, 4'b0010, 1);
        add(2, "dr_hold",     0, 4'b1010, 1, 4'b0000, 1);
        add(10, "right_held", 0, 4'b1000, 1, 4'b0000, 1);
        add(6, "dr_release",  0, 4'b0000, 1, 4'b0000, 1);
        add(2, "dr_release",  0, 4'b0000, 1, 4'b0000, 0);
        add(12, "up_disabled", 0, 4'b0001, 0, 4'b0000, 0);
        add(4, "enable_late", 0, 4'b0001, 1, 4'b0000, 0);
        add(8, "up_rel_idle", 0, 4'b0000, 1, 4'b0000, 0);
        add(6, "up_repress",  0, 4'b0001, 1, 4'b0000, 0);
        add(1, "up_repulse",  0, 4'b0001, 1, 4'b0001, 1);
        add(1, "up_hold",     0, 4'b0001, 1, 4'b0000, 1);
        add(6, "up_rel2",     0, 4'b0000, 1, 4'b0000, 1);
        add(2, "up_rel2",     0, 4'b0000, 1, 4'b0000, 0);
        add(4, "right_cnt",   0, 4'b1000, 1, 4'b0000, 0);
        add(1, "rst_mid_cnt", 1, 4'b1000, 1, 4'b0000, 0);
        add(6, "right_after", 0, 4'b1000, 1, 4'b0000, 0);
        add(1, "right_pulse", 0, 4'b1000, 1, 4'b1000, 1);
        add(2, "right_hold",  0, 4'b1000, 1, 4'b0000, 1);
        add(1, "rst_in_hold", 1, 4'b1000, 1, 4'b0000, 0);
        add(6, "held_thru",   0, 4'b1000, 1, 4'b0000, 0);
        add(1, "held_pulse",  0, 4'b1000, 1, 4'b1000, 1);
        add(6, "right_rel",   0, 4'b0000, 1, 4'b0000, 1);
        add(2, "right_rel",   0, 4'b0000, 1, 4'b0000, 0);
        foreach (tbl[i]) begin
            rst = tbl[i].rst; btn = tbl[i].btn; en = tbl[i].en;
            @(negedge clk);
            chk(tbl[i].nm, {right, left, down, up, busy}, {tbl[i].mv, tbl[i].bz});
        end
        u1_btn = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            chk("dc1_press", {right1, left1, down1, up1, busy1},
                (e == 4) ? 5'b00011 : (e == 5) ? 5'b00001 : 5'b00000);
        end
        u1_btn = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            chk("dc1_release", {right1, left1, down1, up1, busy1}, (e <= 3) ? 5'b00001 : 5'b00000);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_pulse = 0; n_exp = 0; rb = '0; re = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(rb[b] ? 3 : 15) == 0) rb[b] = ~rb[b];
            if ($urandom_range(31) == 0) re = ~re;
            btn = rb; en = re;
            model_step(rb, re);
            @(negedge clk);
            chk("random", {right, left, down, up, busy}, {m_move, m_st != 2'd0});
            if (m_move != 0) n_exp++;
            if (up | down | left | right) n_pulse++;
        end
        checks++;
        if (n_pulse != n_exp || n_exp == 0) begin
            errors++;
            $display("FAIL random_pulse_count: got %0d pulses want %0d (nonzero)", n_pulse, n_exp);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
